// File: rtl/universal_ff_reg.sv
// Register bank of universal flip-flops (D/T/JK/SR per cycle) with a sticky
// SR-illegal flag and a saturating change counter. Edge pulses: UNIVERSAL_FF_EDGE_EN.
module universal_ff_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sr_err,
  output logic [CNT_W-1:0] chg_cnt
`ifdef UNIVERSAL_FF_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] next_q_s;
  logic [WIDTH-1:0] sr_both_s;
  logic             sr_ill_s;
  logic             changed_s;
  logic             cnt_full_s;

  assign sr_both_s  = a & b;
  assign sr_ill_s   = en && (mode == MODE_SR) && (|sr_both_s);
  assign changed_s  = (next_q_s != q);
  assign cnt_full_s = (chg_cnt == {CNT_W{1'b1}});
  assign qb         = ~q;

  // Characteristic equation selected by mode; S=R=1 bits keep their value.
  always_comb begin
    next_q_s = q;
    case (mode)
      MODE_D:  next_q_s = a;
      MODE_T:  next_q_s = q ^ a;
      MODE_JK: next_q_s = (a & ~q) | (~b & q);
      MODE_SR: next_q_s = ((a | (~b & q)) & ~sr_both_s) | (q & sr_both_s);
      default: next_q_s = q;
    endcase
  end

  // State, sticky error flag and saturating change counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= {WIDTH{1'b0}};
      sr_err  <= 1'b0;
      chg_cnt <= {CNT_W{1'b0}};
    end else begin
      if (en) begin
        q <= next_q_s;
        if (changed_s && !cnt_full_s) begin
          chg_cnt <= chg_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          chg_cnt <= chg_cnt;
        end
      end else begin
        q       <= q;
        chg_cnt <= chg_cnt;
      end
      if (sr_ill_s) begin
        sr_err <= 1'b1;
      end else if (clr_err) begin
        sr_err <= 1'b0;
      end else begin
        sr_err <= sr_err;
      end
    end
  end

`ifdef UNIVERSAL_FF_EDGE_EN
  // One-cycle pulses aligned with the new q value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= {WIDTH{1'b0}};
      fall <= {WIDTH{1'b0}};
    end else if (en) begin
      rise <= next_q_s & ~q;
      fall <= ~next_q_s & q;
    end else begin
      rise <= {WIDTH{1'b0}};
      fall <= {WIDTH{1'b0}};
    end
  end
`endif

endmodule

// File: tb/tb_universal_ff_reg.sv
// Scoreboard bench for universal_ff_reg: a default-width instance plus a CNT_W=2
// instance share the stimulus; edge pulses are checked when UNIVERSAL_FF_EDGE_EN is set.
module tb_universal_ff_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       clr_err = 1'b0;

  logic [7:0] q, qb, chg_cnt;
  logic       sr_err;
  logic [7:0] q2, qb2;
  logic [1:0] chg_cnt2;
  logic       sr_err2;
`ifdef UNIVERSAL_FF_EDGE_EN
  logic [7:0] rise, fall, rise2, fall2;
`endif

  universal_ff_reg #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q), .qb(qb), .sr_err(sr_err), .chg_cnt(chg_cnt)
`ifdef UNIVERSAL_FF_EDGE_EN
    , .rise(rise), .fall(fall)
`endif
  );

  universal_ff_reg #(.WIDTH(8), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
    .q(q2), .qb(qb2), .sr_err(sr_err2), .chg_cnt(chg_cnt2)
`ifdef UNIVERSAL_FF_EDGE_EN
    , .rise(rise2), .fall(fall2)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       err;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [7:0] rise;
    logic [7:0] fall;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total = 0;

  logic [7:0] m_q = 8'h00;
  logic       m_err = 1'b0;
  logic [7:0] m_cnt = 8'h00;
  logic [1:0] m_cnt2 = 2'b00;

  function automatic logic [7:0] model_next(input logic [1:0] md, input logic [7:0] av,
                                            input logic [7:0] bv, input logic [7:0] qv);
    logic [7:0] n;
    for (int i = 0; i < 8; i++) begin
      case (md)
        2'b00: n[i] = av[i];
        2'b01: n[i] = av[i] ? ~qv[i] : qv[i];
        2'b10: case ({av[i], bv[i]})
                 2'b00: n[i] = qv[i];
                 2'b01: n[i] = 1'b0;
                 2'b10: n[i] = 1'b1;
                 default: n[i] = ~qv[i];
               endcase
        default: case ({av[i], bv[i]})
                 2'b01: n[i] = 1'b0;
                 2'b10: n[i] = 1'b1;
                 default: n[i] = qv[i];
               endcase
      endcase
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Drive one cycle of stimulus, push the model's expectation, compare after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] md,
                      input logic [7:0] av, input logic [7:0] bv, input logic ce);
    exp_t x;
    logic [7:0] nq;
    @(negedge clk);
    rst = r; en = e; mode = md; a = av; b = bv; clr_err = ce;
    x.rise = 8'h00;
    x.fall = 8'h00;
    if (r) begin
      m_q = 8'h00; m_err = 1'b0; m_cnt = 8'h00; m_cnt2 = 2'b00;
    end else begin
      nq = model_next(md, av, bv, m_q);
      if (e && md == 2'b11 && (av & bv) != 8'h00) m_err = 1'b1;
      else if (ce) m_err = 1'b0;
      if (e) begin
        x.rise = nq & ~m_q;
        x.fall = ~nq & m_q;
        if (nq != m_q) begin
          if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
          if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
        end
        m_q = nq;
      end
    end
    x.q = m_q; x.err = m_err; x.cnt = m_cnt; x.cnt2 = m_cnt2;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
    end else begin
      x = sb.pop_front();
      check({tag, "_q"}, q, x.q);
      check({tag, "_qb"}, qb, ~x.q);
      check({tag, "_err"}, {7'd0, sr_err}, {7'd0, x.err});
      check({tag, "_cnt"}, chg_cnt, x.cnt);
      check({tag, "_cnt2"}, {6'd0, chg_cnt2}, {6'd0, x.cnt2});
      check({tag, "_q2"}, q2, x.q);
`ifdef UNIVERSAL_FF_EDGE_EN
      check({tag, "_rise"}, rise, x.rise);
      check({tag, "_fall"}, fall, x.fall);
`endif
    end
  endtask

  initial begin
    // Reset wins over en=0
    step("rst", 1'b1, 1'b0, 2'b00, 8'hFF, 8'h00, 1'b0);
    check("rst_q", q, 8'h00);
    check("rst_qb", qb, 8'hFF);
    check("rst_cnt", chg_cnt, 8'h00);
    check("rst_err", {7'd0, sr_err}, 8'h00);

    step("d", 1'b0, 1'b1, 2'b00, 8'hA5, 8'h00, 1'b0);
    check("d_q", q, 8'hA5);
    check("d_cnt", chg_cnt, 8'h01);
    step("t", 1'b0, 1'b1, 2'b01, 8'h0F, 8'hFF, 1'b0);
    check("t_q", q, 8'hAA);
    check("t_cnt", chg_cnt, 8'h02);

    step("jk", 1'b0, 1'b1, 2'b10, 8'hF0, 8'h3C, 1'b0);
    check("jk_q", q, 8'hD2);

    step("d0", 1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0);
    step("sr", 1'b0, 1'b1, 2'b11, 8'h81, 8'h01, 1'b0);
    check("sr_q", q, 8'h80);
    check("sr_err", {7'd0, sr_err}, 8'h01);
    step("sr_clr", 1'b0, 1'b1, 2'b11, 8'h00, 8'h00, 1'b1);
    check("sr_clr_err", {7'd0, sr_err}, 8'h00);
    step("sr_set_wins", 1'b0, 1'b1, 2'b11, 8'h01, 8'h01, 1'b1);
    check("sr_set_wins_err", {7'd0, sr_err}, 8'h01);

    for (int i = 0; i < 3; i++)
      step("hold", 1'b0, 1'b0, 2'($urandom_range(3)), 8'($urandom), 8'($urandom), 1'b0);
    check("hold_q", q, 8'h80);
    check("small_sat", {6'd0, chg_cnt2}, 8'h03);
    step("hold_clr", 1'b0, 1'b0, 2'b11, 8'hFF, 8'hFF, 1'b1);
    check("hold_clr_err", {7'd0, sr_err}, 8'h00);

    step("mid_rst", 1'b1, 1'b1, 2'b00, 8'hFF, 8'h00, 1'b0);
    step("d0f", 1'b0, 1'b1, 2'b00, 8'h0F, 8'h00, 1'b0);
    step("d3c", 1'b0, 1'b1, 2'b00, 8'h3C, 8'h00, 1'b0);
`ifdef UNIVERSAL_FF_EDGE_EN
    check("edge_rise", rise, 8'h30);
    check("edge_fall", fall, 8'h03);
`endif
    step("edge_off", 1'b0, 1'b0, 2'b00, 8'hFF, 8'h00, 1'b0);
`ifdef UNIVERSAL_FF_EDGE_EN
    check("edge_off_rise", rise, 8'h00);
    check("edge_off_fall", fall, 8'h00);
`endif

    // Drive the wide counter into saturation
    for (int i = 0; i < 260; i++)
      step("sat", 1'b0, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b0);
    check("sat_cnt", chg_cnt, 8'hFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
